wb_stage: RTL and testbench

- MEM/WB pipeline register plus writeback logic for the MIPS pipeline.
- Latches the MEM-stage results and selects the data to write: ALU result, load data or link address.
- Aligns and extends sub-word loads, and produces the write address, data and enable that feed the register file write port and the EX forwarding unit.
- Keeps a retired-instruction counter for the debug unit.

---
 rtl/mips_pkg.sv | 41 ++++
 rtl/load_aligner.sv | 57 +++++
 rtl/wb_stage.sv | 144 ++++++++++++++
 tb/tb_wb_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared constants and helpers for the MIPS pipeline.
//                Load-type codes (low 3 opcode bits), special register
//                indices, and a classifier that maps a load type to its
//                access size.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

   // Load size/sign codes, taken from the low three opcode bits
   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b011;
   localparam logic [2:0] LD_LBU = 3'b100;
   localparam logic [2:0] LD_LHU = 3'b101;

   // Architectural register indices
   localparam logic [4:0] REG_RA   = 5'd31;
   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } ld_size_e;

   // Unused codes (010/110/111) behave as full-word loads.
   function automatic ld_size_e ld_size(input logic [2:0] load_type);
      ld_size_e sz;
      case (load_type)
         LD_LB, LD_LBU: sz = SZ_BYTE;
         LD_LH, LD_LHU: sz = SZ_HALF;
         default:       sz = SZ_WORD;
      endcase
      return sz;
   endfunction

endpackage
`default_nettype wire

// File: rtl/load_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : load_aligner
//  Description : Combinational little-endian load alignment. Selects the
//                addressed byte/halfword from the raw memory word, sign- or
//                zero-extends it, and flags accesses that break natural
//                alignment for their size.
//  Ports       : rdata_i      raw word from data memory
//                load_type_i  load size/sign code
//                offset_i     low two address bits
//                data_o       aligned, extended load value
//                misaligned_o access offset not a multiple of its size
//  Revision    : 1.0 - initial release
// ============================================================================
module load_aligner
   import mips_pkg::*;
#(
   parameter int NB_DATA = 32
) (
   input  logic [NB_DATA-1:0] rdata_i,
   input  logic [2:0]         load_type_i,
   input  logic [1:0]         offset_i,
   output logic [NB_DATA-1:0] data_o,
   output logic               misaligned_o
);

   logic [7:0]  byte_w;
   logic [15:0] half_w;

   assign byte_w = rdata_i[{offset_i, 3'b000} +: 8];
   // Halfword picks lane 0 or 2 from offset[1]; offset[0] only matters for
   // the alignment flag, so a misaligned LH still shows a defined value.
   assign half_w = rdata_i[{offset_i[1], 4'b0000} +: 16];

   always_comb begin
      data_o       = rdata_i;
      misaligned_o = 1'b0;
      case (ld_size(load_type_i))
         SZ_BYTE: begin
            // Bit 2 of the load type is the unsigned flag (LBU/LHU)
            data_o = load_type_i[2] ? {{(NB_DATA-8){1'b0}}, byte_w}
                                    : {{(NB_DATA-8){byte_w[7]}}, byte_w};
         end
         SZ_HALF: begin
            data_o = load_type_i[2] ? {{(NB_DATA-16){1'b0}}, half_w}
                                    : {{(NB_DATA-16){half_w[15]}}, half_w};
            misaligned_o = offset_i[0];
         end
         default: begin
            data_o       = rdata_i;
            misaligned_o = |offset_i;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage
//  Description : MEM/WB pipeline register and writeback select. Latches the
//                MEM-stage results, chooses link address / aligned load / ALU
//                result, and drives the register file write port. Also keeps
//                a wrapping count of retired (valid) instructions.
//  Ports       : i_clk, i_reset (async, active high), i_enable (advance)
//                i_valid, i_reg_write, i_mem_to_reg, i_link   control
//                i_load_type, i_byte_offset                     load shape
//                i_alu_result, i_mem_rdata, i_return_addr       data sources
//                i_rd_addr                                      destination
//                o_wb_addr, o_wb_data, o_wb_write               RF write port
//                o_misaligned                                   load fault
//                o_retired_count                                debug counter
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_stage
   import mips_pkg::*;
#(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 5,
   parameter int NB_CNT  = 32
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_enable,
   input  logic               i_valid,
   input  logic               i_reg_write,
   input  logic               i_mem_to_reg,
   input  logic               i_link,
   input  logic [2:0]         i_load_type,
   input  logic [1:0]         i_byte_offset,
   input  logic [NB_DATA-1:0] i_alu_result,
   input  logic [NB_DATA-1:0] i_mem_rdata,
   input  logic [NB_DATA-1:0] i_return_addr,
   input  logic [NB_ADDR-1:0] i_rd_addr,
   output logic [NB_ADDR-1:0] o_wb_addr,
   output logic [NB_DATA-1:0] o_wb_data,
   output logic               o_wb_write,
   output logic               o_misaligned,
   output logic [NB_CNT-1:0]  o_retired_count
);

   logic               valid_q;
   logic               reg_write_q;
   logic               mem_to_reg_q;
   logic               link_q;
   logic [2:0]         load_type_q;
   logic [1:0]         byte_offset_q;
   logic [NB_DATA-1:0] alu_result_q;
   logic [NB_DATA-1:0] mem_rdata_q;
   logic [NB_DATA-1:0] return_addr_q;
   logic [NB_ADDR-1:0] rd_addr_q;
   logic [NB_CNT-1:0]  count_q;
   logic [NB_CNT-1:0]  count_d;

   logic [NB_DATA-1:0] load_data;
   logic               load_misaligned;

   // ------------------------------------------------------------------------
   // Pipeline register: loads on enable, otherwise holds so the register
   // file simply repeats the same write while the debug unit freezes us.
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         valid_q       <= 1'b0;
         reg_write_q   <= 1'b0;
         mem_to_reg_q  <= 1'b0;
         link_q        <= 1'b0;
         load_type_q   <= '0;
         byte_offset_q <= '0;
         alu_result_q  <= '0;
         mem_rdata_q   <= '0;
         return_addr_q <= '0;
         rd_addr_q     <= '0;
      end else if (i_enable) begin
         valid_q       <= i_valid;
         reg_write_q   <= i_reg_write;
         mem_to_reg_q  <= i_mem_to_reg;
         link_q        <= i_link;
         load_type_q   <= i_load_type;
         byte_offset_q <= i_byte_offset;
         alu_result_q  <= i_alu_result;
         mem_rdata_q   <= i_mem_rdata;
         return_addr_q <= i_return_addr;
         rd_addr_q     <= i_rd_addr;
      end
   end

   // ------------------------------------------------------------------------
   // Retired counter: an instruction is counted as it enters writeback, so
   // the count already includes the instruction currently on the outputs.
   // Misaligned loads still count; bubbles do not. Wraps naturally.
   // ------------------------------------------------------------------------
   always_comb begin
      count_d = count_q;
      if (i_enable && i_valid) begin
         count_d = count_q + {{(NB_CNT-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   load_aligner #(
      .NB_DATA (NB_DATA)
   ) u_load_aligner (
      .rdata_i      (mem_rdata_q),
      .load_type_i  (load_type_q),
      .offset_i     (byte_offset_q),
      .data_o       (load_data),
      .misaligned_o (load_misaligned)
   );

   // ------------------------------------------------------------------------
   // Writeback outputs, combinational from the latched fields
   // ------------------------------------------------------------------------
   always_comb begin
      o_misaligned = valid_q && mem_to_reg_q && load_misaligned;

      // Priority: link > memory > ALU
      if (link_q) begin
         o_wb_data = return_addr_q;
      end else if (mem_to_reg_q) begin
         o_wb_data = load_data;
      end else begin
         o_wb_data = alu_result_q;
      end

      o_wb_addr  = rd_addr_q;
      o_wb_write = valid_q && reg_write_q && !o_misaligned
                   && (rd_addr_q != NB_ADDR'(REG_ZERO));
   end

   assign o_retired_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_stage
//  Description : Self-checking bench for wb_stage. A behavioural model
//                tracks the instruction sitting in writeback and the retired
//                count; every clock the DUT outputs are compared with it.
//                Directed literal cases pin the model, then randomized
//                traffic with stalls and asynchronous resets follows.
//                The counter is built 4 bits wide so wrap-around occurs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

   localparam int NB_CNT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        valid = 1'b0;
   logic        rw = 1'b0;
   logic        m2r = 1'b0;
   logic        lnk = 1'b0;
   logic [2:0]  lt = '0;
   logic [1:0]  off = '0;
   logic [31:0] alu = '0;
   logic [31:0] rdata = '0;
   logic [31:0] ret = '0;
   logic [4:0]  rd = '0;

   logic [4:0]        w_addr;
   logic [31:0]       w_data;
   logic              w_write;
   logic              w_mis;
   logic [NB_CNT-1:0] w_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   wb_stage #(
      .NB_DATA (32),
      .NB_ADDR (5),
      .NB_CNT  (NB_CNT)
   ) dut (
      .i_clk           (clk),
      .i_reset         (rst),
      .i_enable        (en),
      .i_valid         (valid),
      .i_reg_write     (rw),
      .i_mem_to_reg    (m2r),
      .i_link          (lnk),
      .i_load_type     (lt),
      .i_byte_offset   (off),
      .i_alu_result    (alu),
      .i_mem_rdata     (rdata),
      .i_return_addr   (ret),
      .i_rd_addr       (rd),
      .o_wb_addr       (w_addr),
      .o_wb_data       (w_data),
      .o_wb_write      (w_write),
      .o_misaligned    (w_mis),
      .o_retired_count (w_cnt)
   );

   // ---------------- behavioural model ----------------
   typedef struct {
      bit        valid;
      bit        rw;
      bit        m2r;
      bit        lnk;
      bit [2:0]  lt;
      bit [1:0]  off;
      bit [31:0] alu;
      bit [31:0] rdata;
      bit [31:0] ret;
      bit [4:0]  rd;
   } instr_t;

   instr_t m;
   int     cnt;

   function automatic void model_clear();
      m = '{default: 0};
      cnt = 0;
   endfunction

   // Value of a load as seen by software: shift the addressed lane down
   // and extend according to the signedness bit of the opcode.
   function automatic bit [31:0] load_value(bit [31:0] word, bit [2:0] t, bit [1:0] o);
      bit [31:0] v;
      if (t[1:0] == 2'b00) begin
         v = (word >> (8 * o)) & 32'hFF;
         if (!t[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (t[1:0] == 2'b01) begin
         v = (word >> (16 * o[1])) & 32'hFFFF;
         if (!t[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
         v = word;
      end
      return v;
   endfunction

   function automatic bit exp_mis(instr_t x);
      bit bad;
      if (x.lt[1:0] == 2'b00)      bad = 1'b0;
      else if (x.lt[1:0] == 2'b01) bad = (x.off % 2) == 1;
      else                         bad = x.off != 0;
      return x.valid && x.m2r && bad;
   endfunction

   function automatic bit [31:0] exp_data(instr_t x);
      if (x.lnk) return x.ret;
      if (x.m2r) return load_value(x.rdata, x.lt, x.off);
      return x.alu;
   endfunction

   function automatic bit exp_write(instr_t x);
      return x.valid && x.rw && !exp_mis(x) && x.rd != 0;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic compare();
      chk("wb_addr",  32'(w_addr),  32'(m.rd));
      chk("wb_data",  w_data,       exp_data(m));
      chk("wb_write", 32'(w_write), 32'(exp_write(m)));
      chk("misalign", 32'(w_mis),   32'(exp_mis(m)));
      chk("count",    32'(w_cnt),   32'(cnt % (1 << NB_CNT)));
   endtask

   // One clock: model latches the inputs present at the edge, then the DUT
   // outputs are compared 1 time unit later.
   task automatic step();
      instr_t x;
      @(posedge clk);
      x.valid = valid; x.rw = rw; x.m2r = m2r; x.lnk = lnk;
      x.lt = lt; x.off = off; x.alu = alu; x.rdata = rdata;
      x.ret = ret; x.rd = rd;
      if (en) begin
         m = x;
         if (x.valid) cnt++;
      end
      #1;
      compare();
   endtask

   task automatic set_in(bit v, bit w, bit mr, bit lk, bit [2:0] t, bit [1:0] o,
                         bit [31:0] a, bit [31:0] d, bit [31:0] r, bit [4:0] dst);
      valid = v; rw = w; m2r = mr; lnk = lk; lt = t; off = o;
      alu = a; rdata = d; ret = r; rd = dst;
   endtask

   task automatic check_zero(string nm);
      chk({nm, "_addr"},  32'(w_addr),  32'h0);
      chk({nm, "_data"},  w_data,       32'h0);
      chk({nm, "_write"}, 32'(w_write), 32'h0);
      chk({nm, "_mis"},   32'(w_mis),   32'h0);
      chk({nm, "_cnt"},   32'(w_cnt),   32'h0);
   endtask

   // Called at edge+1: assert reset between edges, outputs must clear
   // without any clock edge, then release away from the edge.
   task automatic async_reset();
      #2 rst = 1'b1;
      #1 check_zero("rst_async");
      model_clear();
      @(posedge clk);
      #1 rst = 1'b0;
      compare();
   endtask

   localparam logic [31:0] RW = 32'h80FF_7F01;

   initial begin
      model_clear();
      // Reset applied from time 0; first posedge is at t=5
      #3 check_zero("rst_init");
      @(posedge clk);
      #1 rst = 1'b0;
      en = 1'b1;

      // ALU writeback
      set_in(1, 1, 0, 0, 3'b000, 2'd0, 32'h0000_1234, 32'h0, 32'h0, 5'd8);
      step();
      chk("alu_addr",  32'(w_addr),  32'd8);
      chk("alu_data",  w_data,       32'h0000_1234);
      chk("alu_write", 32'(w_write), 32'd1);
      chk("alu_cnt",   32'(w_cnt),   32'd1);

      // Sub-word loads
      set_in(1, 1, 1, 0, 3'b000, 2'd3, 32'h0, RW, 32'h0, 5'd9); step();
      chk("lb_off3",  w_data, 32'hFFFF_FF80);
      set_in(1, 1, 1, 0, 3'b100, 2'd1, 32'h0, RW, 32'h0, 5'd9); step();
      chk("lbu_off1", w_data, 32'h0000_007F);
      set_in(1, 1, 1, 0, 3'b001, 2'd2, 32'h0, RW, 32'h0, 5'd9); step();
      chk("lh_off2",  w_data, 32'hFFFF_80FF);
      set_in(1, 1, 1, 0, 3'b101, 2'd0, 32'h0, RW, 32'h0, 5'd9); step();
      chk("lhu_off0", w_data, 32'h0000_7F01);
      set_in(1, 1, 1, 0, 3'b011, 2'd0, 32'h0, RW, 32'h0, 5'd9); step();
      chk("lw_off0",  w_data, 32'h80FF_7F01);
      chk("lw_write", 32'(w_write), 32'd1);
      chk("lw_cnt",   32'(w_cnt),   32'd6);

      // Misaligned halfword still counts
      set_in(1, 1, 1, 0, 3'b001, 2'd1, 32'h0, RW, 32'h0, 5'd9); step();
      chk("lh1_mis",   32'(w_mis),   32'd1);
      chk("lh1_write", 32'(w_write), 32'd0);
      chk("lh1_cnt",   32'(w_cnt),   32'd7);

      // Word load to $zero
      set_in(1, 1, 1, 0, 3'b011, 2'd0, 32'h0, RW, 32'h0, 5'd0); step();
      chk("r0_write", 32'(w_write), 32'd0);

      // Link beats memory
      set_in(1, 1, 1, 1, 3'b011, 2'd0, 32'h0, RW, 32'h0000_0048, 5'd31); step();
      chk("jal_data",  w_data,       32'h0000_0048);
      chk("jal_write", 32'(w_write), 32'd1);
      chk("jal_cnt",   32'(w_cnt),   32'd9);

      // Stall for 3 edges with different inputs present
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_in(1, 1, 0, 0, 3'b000, 2'd0, $urandom, $urandom, $urandom, 5'd4);
         step();
      end
      chk("stall_addr", 32'(w_addr), 32'd31);
      chk("stall_data", w_data,      32'h0000_0048);
      chk("stall_cnt",  32'(w_cnt),  32'd9);
      en = 1'b1;

      // Bubble
      set_in(0, 1, 0, 0, 3'b000, 2'd0, 32'h55, 32'h0, 32'h0, 5'd3); step();
      chk("bub_write", 32'(w_write), 32'd0);
      chk("bub_cnt",   32'(w_cnt),   32'd9);

      // Counter wrap (4-bit)
      for (int i = 0; i < 6; i++) begin
         set_in(1, 1, 0, 0, 3'b000, 2'd0, 32'(i), 32'h0, 32'h0, 5'd2);
         step();
      end
      chk("cnt_15", 32'(w_cnt), 32'd15);
      step();
      chk("cnt_wrap", 32'(w_cnt), 32'd0);

      // Reset in the middle of operation
      async_reset();

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         en = ($urandom_range(0, 4) != 0);
         set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                1'($urandom), $urandom_range(0, 5) == 0,
                3'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
                ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
         step();
         if ($urandom_range(0, 199) == 0) async_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
